// File: rtl/pwm_ramp_seq_if.sv
// Signal bundle for pwm_ramp_seq: the TL-UL style host register port and the
// PWM register write port. The sequencer takes the slave view; its environment the master view.
interface pwm_ramp_seq_if;
    logic        re_i;
    logic        we_i;
    logic [7:0]  addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        error_o;
    logic        pwm_we_o;
    logic        pwm_re_o;
    logic [7:0]  pwm_addr_o;
    logic [31:0] pwm_wdata_o;
    logic        busy_o;
    logic        done_o;

    modport slave (
        input  re_i, we_i, addr_i, wdata_i,
        output rdata_o, error_o, pwm_we_o, pwm_re_o, pwm_addr_o, pwm_wdata_o, busy_o, done_o
    );

    modport master (
        output re_i, we_i, addr_i, wdata_i,
        input  rdata_o, error_o, pwm_we_o, pwm_re_o, pwm_addr_o, pwm_wdata_o, busy_o, done_o
    );
endinterface

// File: rtl/pwm_ramp_seq.sv
// PWM duty-cycle ramp sequencer: programs one PWM channel, then steps its duty
// cycle from START_DC to TARGET_DC with a programmable dwell between steps.
module pwm_ramp_seq #(
    parameter logic [7:0]  CH1_BASE = 8'h00,
    parameter logic [7:0]  CH2_BASE = 8'h10,
    parameter int unsigned DW       = 16
) (
    input logic           clk_i,
    input logic           rst_ni,
    pwm_ramp_seq_if.slave bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_WR_RST, S_WR_DIV, S_WR_PER, S_WR_DC, S_WR_RUN,
        S_DWELL, S_STEP_WR, S_DONE, S_WR_STOP
    } state_e;

    localparam logic [2:0] R_DIV = 3'd0, R_PER = 3'd1, R_START = 3'd2,
                           R_TGT = 3'd3, R_STEP = 3'd4, R_DWELL = 3'd5, R_CMD = 3'd6;

    state_e          state_q, state_d;
    logic [DW-1:0]   cfg_q [6];
    logic [DW-1:0]   cfg_d [6];
    logic [DW-1:0]   cur_dc_q, cur_dc_d;
    logic [DW-1:0]   dwell_cnt_q, dwell_cnt_d;
    logic            chsel_q, chsel_d;
    logic            done_q, done_d;

    logic [2:0]      idx;
    logic            mapped, host_wr, busy, cmd_wr;
    logic            start_req, abort_req, clr_req, start_ok, abort_ok, cfg_locked;
    logic [7:0]      base;
    logic [DW-1:0]   step_eff, dwell_load, next_dc;
    logic [DW:0]     up_sum, dn_diff;
    logic            unused_wdata;

    assign idx        = bus.addr_i[4:2];
    assign mapped     = (bus.addr_i[1:0] == 2'b00) && (bus.addr_i[7:5] == 3'b000) && (idx != 3'd7);
    assign host_wr    = bus.we_i & ~bus.re_i;
    assign busy       = (state_q != S_IDLE);
    assign cmd_wr     = host_wr & mapped & (idx == R_CMD);
    assign start_req  = cmd_wr & bus.wdata_i[0];
    assign abort_req  = cmd_wr & bus.wdata_i[1];
    assign clr_req    = cmd_wr & bus.wdata_i[3];
    assign start_ok   = start_req & ~abort_req & ~busy;
    assign abort_ok   = abort_req & busy;
    // DWELL stays writable mid-ramp; the ramp shape registers are frozen.
    assign cfg_locked = busy & (idx <= R_STEP);
    assign base       = chsel_q ? CH2_BASE : CH1_BASE;
    assign unused_wdata = ^bus.wdata_i[31:DW];

    assign bus.error_o = ((bus.re_i | bus.we_i) & ~mapped)
                       | (host_wr & mapped & cfg_locked)
                       | (start_req & ~abort_req & busy);
    assign bus.pwm_re_o = 1'b0;
    assign bus.busy_o   = busy;
    assign bus.done_o   = done_q;

    always_comb begin
        bus.rdata_o = 32'h0;
        if (mapped) begin
            if (idx == R_CMD) bus.rdata_o = {16'(cur_dc_q), 12'b0, chsel_q, done_q, busy, 1'b0};
            else              bus.rdata_o = 32'(cfg_q[idx]);
        end
    end

    // Saturating step in DW+1 bits so neither direction can wrap past the target.
    always_comb begin
        step_eff   = (cfg_q[R_STEP] == '0) ? DW'(1) : cfg_q[R_STEP];
        dwell_load = (cfg_q[R_DWELL] == '0) ? '0 : cfg_q[R_DWELL] - DW'(1);
        up_sum     = {1'b0, cur_dc_q} + {1'b0, step_eff};
        dn_diff    = {1'b0, cur_dc_q} - {1'b0, step_eff};
        if (cfg_q[R_TGT] > cur_dc_q)
            next_dc = (up_sum > {1'b0, cfg_q[R_TGT]}) ? cfg_q[R_TGT] : up_sum[DW-1:0];
        else
            next_dc = (dn_diff[DW] || (dn_diff[DW-1:0] < cfg_q[R_TGT])) ? cfg_q[R_TGT] : dn_diff[DW-1:0];
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        cfg_d = cfg_q;
        if (host_wr && mapped && idx <= R_DWELL && !cfg_locked) cfg_d[idx] = bus.wdata_i[DW-1:0];
    end

    always_comb begin
        state_d         = state_q;
        cur_dc_d        = cur_dc_q;
        dwell_cnt_d     = dwell_cnt_q;
        chsel_d         = chsel_q;
        done_d          = done_q;
        bus.pwm_we_o    = 1'b0;
        bus.pwm_addr_o  = 8'h00;
        bus.pwm_wdata_o = 32'h0;

        unique case (state_q)
            S_IDLE: if (start_ok) begin
                state_d = S_WR_RST;
                chsel_d = bus.wdata_i[2];
            end
            S_WR_RST: begin
                bus.pwm_we_o = 1'b1; bus.pwm_addr_o = base; bus.pwm_wdata_o = 32'h80;
                state_d = S_WR_DIV;
            end
            S_WR_DIV: begin
                bus.pwm_we_o = 1'b1; bus.pwm_addr_o = base + 8'd4; bus.pwm_wdata_o = 32'(cfg_q[R_DIV]);
                state_d = S_WR_PER;
            end
            S_WR_PER: begin
                bus.pwm_we_o = 1'b1; bus.pwm_addr_o = base + 8'd8; bus.pwm_wdata_o = 32'(cfg_q[R_PER]);
                state_d = S_WR_DC;
            end
            S_WR_DC: begin
                bus.pwm_we_o = 1'b1; bus.pwm_addr_o = base + 8'd12; bus.pwm_wdata_o = 32'(cfg_q[R_START]);
                cur_dc_d = cfg_q[R_START];
                state_d  = S_WR_RUN;
            end
            S_WR_RUN: begin
                bus.pwm_we_o = 1'b1; bus.pwm_addr_o = base; bus.pwm_wdata_o = 32'h14;
                dwell_cnt_d  = dwell_load;
                state_d      = (cur_dc_q == cfg_q[R_TGT]) ? S_DONE : S_DWELL;
            end
            S_DWELL: begin
                if (dwell_cnt_q == '0) state_d = S_STEP_WR;
                else                   dwell_cnt_d = dwell_cnt_q - DW'(1);
            end
            S_STEP_WR: begin
                bus.pwm_we_o = 1'b1; bus.pwm_addr_o = base + 8'd12; bus.pwm_wdata_o = 32'(next_dc);
                cur_dc_d     = next_dc;
                dwell_cnt_d  = dwell_load;
                state_d      = (next_dc == cfg_q[R_TGT]) ? S_DONE : S_DWELL;
            end
            S_DONE:    state_d = S_IDLE;
            S_WR_STOP: begin
                bus.pwm_we_o = 1'b1; bus.pwm_addr_o = base; bus.pwm_wdata_o = 32'h0;
                state_d = S_IDLE;
            end
            default:   state_d = S_IDLE;
        endcase

        if (abort_ok) state_d = S_WR_STOP;
        // Completion is applied last so it wins over a coincident clear.
        if (clr_req || start_ok)                done_d = 1'b0;
        if (state_q == S_DONE && !abort_ok)     done_d = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the small config array is reset like any other register; it is flops, not a RAM macro.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            cur_dc_q    <= '0;
            dwell_cnt_q <= '0;
            chsel_q     <= 1'b0;
            done_q      <= 1'b0;
            for (int i = 0; i < 6; i++) cfg_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            cur_dc_q    <= cur_dc_d;
            dwell_cnt_q <= dwell_cnt_d;
            chsel_q     <= chsel_d;
            done_q      <= done_d;
            cfg_q       <= cfg_d;
        end
    end
endmodule

// File: tb/tb_pwm_ramp_seq.sv
// Directed bench for pwm_ramp_seq: expected PWM writes (address, data, cycle)
// are queued as each ramp is launched and a monitor pops them on every write strobe.
module tb_pwm_ramp_seq;
    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;
    int   pwm_cnt = 0;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    pwm_ramp_seq_if bus ();

    pwm_ramp_seq dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check(name, {31'b0, act}, {31'b0, exp});
    endtask

    always @(negedge clk) begin
        if (rst_ni && bus.pwm_we_o) begin
            pwm_cnt++;
            if (sb_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL pwm_unexpected: got addr=%h data=%h at cycle %0d, expected no write",
                         bus.pwm_addr_o, bus.pwm_wdata_o, cyc);
            end else begin
                mon_e = sb_q.pop_front();
                check("pwm_addr", {24'b0, bus.pwm_addr_o}, {24'b0, mon_e.addr});
                check("pwm_data", bus.pwm_wdata_o, mon_e.data);
                check("pwm_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] a, input logic [31:0] d, input int c);
        exp_t e;
        e.addr = a; e.data = d; e.cyc = c;
        sb_q.push_back(e);
    endtask

    task automatic push_setup(input logic [7:0] base, input logic [31:0] div, input logic [31:0] per,
                              input logic [31:0] sdc, input int t);
        push(base,         32'h80, t + 1);
        push(base + 8'd4,  div,    t + 2);
        push(base + 8'd8,  per,    t + 3);
        push(base + 8'd12, sdc,    t + 4);
        push(base,         32'h14, t + 5);
    endtask

    task automatic host_write(input logic [7:0] a, input logic [31:0] d, input logic exp_err);
        bus.we_i = 1'b1; bus.re_i = 1'b0; bus.addr_i = a; bus.wdata_i = d;
        #1;
        check1("wr_error", bus.error_o, exp_err);
        step();
        bus.we_i = 1'b0;
    endtask

    task automatic host_read(input logic [7:0] a, input logic [31:0] exp_data, input logic exp_err);
        bus.re_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = a;
        #1;
        check("rd_data", bus.rdata_o, exp_data);
        check1("rd_error", bus.error_o, exp_err);
        bus.re_i = 1'b0;
    endtask

    task automatic cfg(input int div, input int per, input int sdc, input int tgt, input int stp, input int dw);
        host_write(8'h00, 32'(div), 1'b0);
        host_write(8'h04, 32'(per), 1'b0);
        host_write(8'h08, 32'(sdc), 1'b0);
        host_write(8'h0C, 32'(tgt), 1'b0);
        host_write(8'h10, 32'(stp), 1'b0);
        host_write(8'h14, 32'(dw),  1'b0);
    endtask

    task automatic wait_idle(input int max_cyc);
        int n = 0;
        while (bus.busy_o && n < max_cyc) begin
            step();
            n++;
        end
        check1("idle_timeout", bus.busy_o, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        int w0;
        bus.re_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = 8'h00; bus.wdata_i = 32'h0;
        repeat (3) step();
        check1("rst_pwm_we", bus.pwm_we_o, 1'b0);
        check1("rst_pwm_re", bus.pwm_re_o, 1'b0);
        check1("rst_busy", bus.busy_o, 1'b0);
        check1("rst_done", bus.done_o, 1'b0);
        check("rst_pwm_wdata", bus.pwm_wdata_o, 32'h0);
        host_read(8'h18, 32'h0, 1'b0);
        rst_ni = 1'b1;
        step();

        // Up-ramp on CH1: 0 -> 30 in steps of 10, dwell 3.
        cfg(4, 100, 0, 30, 10, 3);
        t = cyc;
        push_setup(8'h00, 32'd4, 32'd100, 32'd0, t);
        push(8'h0C, 32'd10, t + 9);
        push(8'h0C, 32'd20, t + 13);
        push(8'h0C, 32'd30, t + 17);
        host_write(8'h18, 32'h1, 1'b0);
        repeat (17) step();
        check1("up_busy_t18", bus.busy_o, 1'b1);
        check1("up_done_t18", bus.done_o, 1'b0);
        step();
        check1("up_done_t19", bus.done_o, 1'b1);
        check1("up_busy_t19", bus.busy_o, 1'b0);
        host_read(8'h18, 32'h001E_0004, 1'b0);

        // Down-ramp on CH2 with clamp at 5.
        cfg(4, 100, 50, 5, 20, 1);
        t = cyc;
        push_setup(8'h10, 32'd4, 32'd100, 32'd50, t);
        push(8'h1C, 32'd30, t + 7);
        push(8'h1C, 32'd10, t + 9);
        push(8'h1C, 32'd5,  t + 11);
        host_write(8'h18, 32'h5, 1'b0);
        check1("dn_start_clears_done", bus.done_o, 1'b0);
        check1("dn_busy_t1", bus.busy_o, 1'b1);
        repeat (11) step();
        check1("dn_busy_t12", bus.busy_o, 1'b1);
        step();
        check1("dn_done_t13", bus.done_o, 1'b1);
        host_read(8'h18, 32'h0005_000C, 1'b0);

        // Clear done, then START == TARGET: exactly five writes.
        host_write(8'h18, 32'h8, 1'b0);
        check1("clr_done", bus.done_o, 1'b0);
        cfg(4, 100, 40, 40, 10, 3);
        w0 = pwm_cnt;
        t = cyc;
        push_setup(8'h00, 32'd4, 32'd100, 32'd40, t);
        host_write(8'h18, 32'h1, 1'b0);
        repeat (5) step();
        check1("eq_busy_done_state", bus.busy_o, 1'b1);
        step();
        check1("eq_done", bus.done_o, 1'b1);
        check1("eq_idle", bus.busy_o, 1'b0);
        check("eq_write_count", 32'(pwm_cnt - w0), 32'd5);

        // STEP=0 and DWELL=0 behave as 1.
        cfg(4, 100, 0, 3, 0, 0);
        t = cyc;
        push_setup(8'h00, 32'd4, 32'd100, 32'd0, t);
        push(8'h0C, 32'd1, t + 7);
        push(8'h0C, 32'd2, t + 9);
        push(8'h0C, 32'd3, t + 11);
        host_write(8'h18, 32'h1, 1'b0);
        repeat (11) step();
        check1("min_busy_t12", bus.busy_o, 1'b1);
        step();
        check1("min_done_t13", bus.done_o, 1'b1);

        // Abort during the second dwell.
        cfg(4, 100, 0, 30, 10, 3);
        t = cyc;
        push_setup(8'h00, 32'd4, 32'd100, 32'd0, t);
        push(8'h0C, 32'd10, t + 9);
        host_write(8'h18, 32'h1, 1'b0);
        repeat (10) step();
        push(8'h00, 32'h0, t + 12);
        host_write(8'h18, 32'h2, 1'b0);
        check1("abort_busy_stop", bus.busy_o, 1'b1);
        step();
        check1("abort_idle", bus.busy_o, 1'b0);
        check1("abort_no_done", bus.done_o, 1'b0);
        host_read(8'h18, 32'h000A_0000, 1'b0);

        // Config write and start while busy are rejected.
        t = cyc;
        push_setup(8'h00, 32'd4, 32'd100, 32'd0, t);
        push(8'h0C, 32'd10, t + 9);
        push(8'h0C, 32'd20, t + 13);
        push(8'h0C, 32'd30, t + 17);
        host_write(8'h18, 32'h1, 1'b0);
        step();
        host_write(8'h04, 32'd200, 1'b1);
        host_write(8'h18, 32'h1, 1'b1);
        wait_idle(50);
        host_read(8'h04, 32'd100, 1'b0);
        host_read(8'h40, 32'h0, 1'b1);

        // Reset mid-dwell.
        t = cyc;
        push_setup(8'h00, 32'd4, 32'd100, 32'd0, t);
        host_write(8'h18, 32'h1, 1'b0);
        repeat (6) step();
        rst_ni = 1'b0;
        #1;
        check1("mid_rst_pwm_we", bus.pwm_we_o, 1'b0);
        check("mid_rst_pwm_addr", {24'b0, bus.pwm_addr_o}, 32'h0);
        check("mid_rst_pwm_wdata", bus.pwm_wdata_o, 32'h0);
        check1("mid_rst_busy", bus.busy_o, 1'b0);
        check1("mid_rst_done", bus.done_o, 1'b0);
        host_read(8'h18, 32'h0, 1'b0);
        rst_ni = 1'b1;
        repeat (3) step();
        check1("post_rst_busy", bus.busy_o, 1'b0);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
